// File: rtl/lzx_shift_rx.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits, stop bit, VALID/ACK output.
// Optional even-parity bit and PERR output are enabled with `define LZX_SHIFT_RX_PARITY_EN.
module lzx_shift_rx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVR,
  output logic             FERR
`ifdef LZX_SHIFT_RX_PARITY_EN
  ,
  output logic             PERR
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sr_q,    sr_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;
  logic             ferr_q,  ferr_d;
`ifdef LZX_SHIFT_RX_PARITY_EN
  logic             par_q,   par_d;
  logic             perr_q,  perr_d;
`endif

  logic             ack_take;
  logic             parity_ok;
  logic [WIDTH-1:0] sr_shifted;

  assign ack_take = ACK && valid_q;

  // Shift direction decides whether the first data bit ends up in Q[0] or Q[WIDTH-1].
  always_comb begin
    if (LSB_FIRST) sr_shifted = {SIN, sr_q[WIDTH-1:1]};
    else           sr_shifted = {sr_q[WIDTH-2:0], SIN};
  end

`ifdef LZX_SHIFT_RX_PARITY_EN
  assign parity_ok = ~par_q;
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;
`ifdef LZX_SHIFT_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    // The consumer's ACK is applied first; a word landing on the same edge overrides VALID below.
    if (ack_take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (SEN && !SIN) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef LZX_SHIFT_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      ST_DATA: begin
        if (SEN) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + 1'b1;
`ifdef LZX_SHIFT_RX_PARITY_EN
          par_d = par_q ^ SIN;
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_PAR;
`else
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_STOP;
`endif
        end
      end

      ST_PAR: begin
        if (SEN) begin
`ifdef LZX_SHIFT_RX_PARITY_EN
          par_d = par_q ^ SIN;
`endif
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (SEN) begin
          state_d = ST_IDLE;
          if (!SIN) begin
            ferr_d = 1'b1;
          end else if (parity_ok) begin
            q_d     = sr_q;
            valid_d = 1'b1;
            // Overwriting an unconsumed word is an overrun unless it is being acknowledged now.
            if (valid_q && !ACK) ovr_d = 1'b1;
          end else begin
`ifdef LZX_SHIFT_RX_PARITY_EN
            perr_d = 1'b1;
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef LZX_SHIFT_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
`ifdef LZX_SHIFT_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign OVR   = ovr_q;
  assign FERR  = ferr_q;
`ifdef LZX_SHIFT_RX_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_lzx_shift_rx.sv
// Scoreboard bench for lzx_shift_rx: an LSB-first and an MSB-first receiver share one serial line.
// Build with +define+LZX_SHIFT_RX_PARITY_EN to add the parity frames.
module tb_lzx_shift_rx;

  logic clk = 1'b0;
  logic rst_n, sin, sen, ack;

  logic [3:0] q_l, q_m;
  logic       valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m, ferr_l, ferr_m;
  logic       perr_l, perr_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lzx_shift_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
    .CLK(clk), .MR(rst_n), .SIN(sin), .SEN(sen), .ACK(ack),
    .Q(q_l), .VALID(valid_l), .BUSY(busy_l), .OVR(ovr_l), .FERR(ferr_l)
`ifdef LZX_SHIFT_RX_PARITY_EN
    , .PERR(perr_l)
`endif
  );

  lzx_shift_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
    .CLK(clk), .MR(rst_n), .SIN(sin), .SEN(sen), .ACK(ack),
    .Q(q_m), .VALID(valid_m), .BUSY(busy_m), .OVR(ovr_m), .FERR(ferr_m)
`ifdef LZX_SHIFT_RX_PARITY_EN
    , .PERR(perr_m)
`endif
  );

`ifndef LZX_SHIFT_RX_PARITY_EN
  assign perr_l = 1'b0;
  assign perr_m = 1'b0;
`endif

  typedef struct {
    logic [3:0] q_l;
    logic [3:0] q_m;
    logic       valid;
    logic       ovr;
    logic       ferr;
    logic       perr;
    int         busy;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_frame(input logic [3:0] ql, input logic [3:0] qm, input logic v,
                              input logic o, input logic fe, input logic pe, input int b);
    exp_t e;
    e.q_l = ql; e.q_m = qm; e.valid = v; e.ovr = o; e.ferr = fe; e.perr = pe; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Drives start, four data bits (v[0] first), optional parity bit, then the stop bit.
  task automatic send_word(input logic [3:0] v, input bit toggle, input bit par_bit,
                           input bit stop, input bit ack_on_stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) bits.push_back(v[i]);
`ifdef LZX_SHIFT_RX_PARITY_EN
    bits.push_back(par_bit);
`endif
    bits.push_back(stop);
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge clk);
      sen = 1'b1;
      sin = bits[i];
      if (ack_on_stop && i == bits.size() - 1) ack = 1'b1;
      if (toggle && i != bits.size() - 1) begin
        @(negedge clk);
        sen = 1'b0;
      end
    end
    @(negedge clk);
    sen = 1'b0;
    sin = 1'b1;
    ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name, input logic [3:0] ql, input logic [3:0] qm,
                                    input logic v, input logic o);
    check({name, "_q_lsb"},  q_l, ql);
    check({name, "_q_msb"},  q_m, qm);
    check({name, "_valid"},  {valid_l, valid_m}, {v, v});
    check({name, "_ovr"},    {ovr_l, ovr_m}, {o, o});
    check({name, "_busy"},   {busy_l, busy_m}, 2'b00);
  endtask

  // Monitor: a frame ends when BUSY falls; pop the expected response and compare.
  initial begin
    logic busy_prev;
    int   bcnt;
    exp_t e;
    busy_prev = 1'b0;
    bcnt      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
        bcnt      = 0;
      end else begin
        check("busy_match", busy_m, busy_l);
        if (busy_prev && !busy_l) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame end with no expectation at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("frame_q_lsb", q_l, e.q_l);
            check("frame_q_msb", q_m, e.q_m);
            check("frame_valid", {valid_l, valid_m}, {e.valid, e.valid});
            check("frame_ovr",   {ovr_l, ovr_m}, {e.ovr, e.ovr});
            check("frame_ferr",  {ferr_l, ferr_m}, {e.ferr, e.ferr});
            check("frame_perr",  {perr_l, perr_m}, {e.perr, e.perr});
            check("frame_busy_cycles", bcnt, e.busy);
          end
          bcnt = 0;
        end else begin
          check("no_stray_pulse", {ferr_l, ferr_m, perr_l, perr_m}, 4'b0000);
        end
        if (busy_l) bcnt++;
        busy_prev = busy_l;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    sen   = 1'b0;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    check("reset_ferr", {ferr_l, ferr_m}, 2'b00);
    rst_n = 1'b1;

    // Stream 0,0,1,0,1,1: LSB-first gives A, MSB-first gives 5.
    expect_frame(4'hA, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_word(4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack();
    check_idle_outputs("ack_a", 4'hA, 4'h5, 1'b0, 1'b0);

    // Reset after start bit plus two data bits.
    @(negedge clk); sen = 1'b1; sin = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); sin = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    sen = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    expect_frame(4'h3, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_word(4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack();

    // SEN every other cycle doubles the frame time.
    expect_frame(4'hA, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 10);
    send_word(4'hA, 1'b1, 1'b0, 1'b1, 1'b0);

    // Overrun: a second word arrives while the first is unconsumed.
    expect_frame(4'h5, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    send_word(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack();
    check_idle_outputs("ack_ovr", 4'h5, 4'hA, 1'b0, 1'b0);

    // Framing error: stop bit 0; Q and VALID keep their values.
    expect_frame(4'h5, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    send_word(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_frame(4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_word(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Good stop and ACK together while VALID=1: no overrun, new word valid.
    expect_frame(4'h3, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_word(4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
    do_ack();
    check_idle_outputs("ack_3", 4'h3, 4'hC, 1'b0, 1'b0);

    // Good stop and ACK together while VALID=0: ACK ignored.
    expect_frame(4'h1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_word(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    do_ack();
    check_idle_outputs("ack_1", 4'h1, 4'h8, 1'b0, 1'b0);

`ifdef LZX_SHIFT_RX_PARITY_EN
    // A has two ones: parity bit 1 is wrong, parity bit 0 is right.
    expect_frame(4'h1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 6);
    send_word(4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame(4'hA, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    send_word(4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzx_shift_rx.md
Name: lzx_shift_rx

Overview:
- Serial-in/parallel-out frame receiver: the receiving end of the serial link driven by the team's 4-bit universal shift register running in shift mode (DSR/DSL output stream).
- Hunts for a start bit, deserializes WIDTH data bits, checks the stop bit, and presents the word on a registered parallel bus with a VALID/ACK handshake.
- Sits between the shift-register transmitter and downstream parallel logic; reports overrun and framing errors.

Parameters:
- WIDTH, 4, data bits per frame (legal 2..16).
- LSB_FIRST, 1, 1 = first data bit received lands in Q[0]; 0 = first data bit lands in Q[WIDTH-1].

Ports:
- CLK  input  1  system clock, rising edge.
- MR  input  1  asynchronous active-low reset.
- SIN  input  1  serial data line; idles high.
- SEN  input  1  bit strobe; SIN is sampled only on CLK edges where SEN=1.
- ACK  input  1  consumer accepts the current word; meaningful only while VALID=1.
- Q  output  WIDTH  last good received word (registered).
- VALID  output  1  Q holds an unconsumed word.
- BUSY  output  1  a frame is in progress (state != IDLE).
- OVR  output  1  sticky overrun flag.
- FERR  output  1  one-cycle framing-error pulse.

Behaviour:
- Reset (MR=0, asynchronous, at any time including mid-frame): state=IDLE, bit counter=0, shift register=0, Q=0, VALID=0, BUSY=0, OVR=0, FERR=0. On MR release, operation starts from IDLE on the next qualified edge.
- Frame on SIN, one bit per SEN strobe: start bit (0), then WIDTH data bits, then stop bit (1).
- IDLE: SEN&&SIN=0 -> DATA, counter=0. SEN&&SIN=1 -> stay in IDLE.
- DATA: each SEN shifts SIN into the internal register.
  - LSB_FIRST=1: shift right, entering at the MSB.
  - LSB_FIRST=0: shift left, entering at the LSB.
  - Counter increments; after the WIDTH-th bit -> STOP.
- STOP, on SEN:
  - SIN=1: load Q with the shift register, set VALID=1, -> IDLE.
  - SIN=0: FERR=1 for exactly one cycle, Q and VALID unchanged, word discarded, -> IDLE. The 0 is not treated as a new start bit.
- Cycles with SEN=0 hold all state; there is no timeout.
- Latency: Q and VALID update at the same CLK edge that samples the stop bit.
- BUSY=1 in DATA and STOP (and PAR), combinational from the state.
- Handshake:
  - ACK=1 while VALID=1 clears VALID on the next edge.
  - ACK while VALID=0 is ignored.
  - Q holds its value after ACK until the next good frame.
- Overrun:
  - Good stop with VALID=1 and ACK=0: Q is overwritten, VALID stays 1, OVR=1.
  - OVR stays set until an edge with ACK=1 and VALID=1, which clears it.
- Simultaneous good stop and ACK, with VALID=1: the old word is consumed, the new word is loaded, VALID stays 1, OVR is not set.
- Simultaneous good stop and ACK, with VALID=0: ACK is ignored, the new word is loaded, VALID=1.
- FERR never affects OVR.

Optional Feature:
- Macro: LZX_SHIFT_RX_PARITY_EN.
- Defined:
  - Adds a PAR state between DATA and STOP: one even-parity bit follows the data bits, so XOR(data, parity bit)=0.
  - Adds output PERR (1 bit, reset 0), a one-cycle pulse issued at the stop-bit edge when parity mismatched and the stop bit is good.
  - On a parity mismatch the word is discarded: Q, VALID and OVR are unchanged.
  - A bad stop bit reports FERR only, regardless of parity.
- Undefined: no PAR state, no PERR port; frame length is WIDTH+2 strobes.

Test Plan:
- Reset mid-frame: drive MR=0 after the start bit and 2 data bits, then release -> Q=0, VALID=0, BUSY=0. A clean frame for 4'h3 then yields Q=4'h3.
- WIDTH=4, LSB_FIRST=1, SEN=1 every cycle, SIN=0,0,1,0,1,1 -> BUSY high for 5 cycles; Q=4'hA and VALID=1 after the 6th edge; ACK=1 for 1 cycle -> VALID=0, Q stays 4'hA.
- LSB_FIRST=0, same bit stream -> Q=4'h5. Also with SEN toggling 1/0 every cycle -> same result in twice the time.
- Overrun: receive 4'hA with no ACK, then 4'h5 -> Q=4'h5, VALID=1, OVR=1. Then ACK -> VALID=0, OVR=0.
- Framing: SIN=0,1,1,1,1,0 -> FERR pulses 1 cycle, VALID unchanged, state IDLE. The next good frame for 4'hF -> Q=4'hF.
- With LZX_SHIFT_RX_PARITY_EN: frame for 4'hA with parity bit 1 -> PERR pulse, Q unchanged. The same frame with parity bit 0 -> Q=4'hA, VALID=1.
